// File: rtl/uart_rx_parity.sv
// UART receiver for the XOR-parity link: 2-flop input synchroniser, mid-bit sampling,
// 8 data bits LSB first, one parity bit, one stop bit, with parity and framing error flags.
module uart_rx_parity #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit ODD_PARITY   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t        state, state_n;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          acc, acc_n;
  logic          perr, perr_n;
  logic [7:0]    data_n;
  logic          valid_n, parity_err_n, frame_err_n;

  assign rx_s = sync[1];
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync       <= 2'b11;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      acc        <= 1'b0;
      perr       <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      sync       <= {sync[0], rx};
      cnt        <= cnt_n;
      idx        <= idx_n;
      shift      <= shift_n;
      acc        <= acc_n;
      perr       <= perr_n;
      data       <= data_n;
      valid      <= valid_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    idx_n        = idx;
    shift_n      = shift;
    acc_n        = acc;
    perr_n       = perr;
    data_n       = data;
    valid_n      = 1'b0;
    parity_err_n = parity_err;
    frame_err_n  = frame_err;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
          acc_n   = ODD_PARITY;
        end
      end
      START: begin
        // A start bit that is no longer low at its midpoint is dropped as a glitch.
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          shift_n[idx] = rx_s;
          acc_n        = acc ^ rx_s;
          cnt_n        = '0;
          idx_n        = idx + 3'd1;
          if (idx == 3'd7) state_n = PARITY;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PARITY: begin
        if (cnt == LAST) begin
          perr_n  = acc ^ rx_s;
          cnt_n   = '0;
          state_n = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        // Leaving STOP on the sample cycle keeps back-to-back start edges visible in IDLE.
        if (cnt == LAST) begin
          data_n       = shift;
          parity_err_n = perr;
          frame_err_n  = !rx_s;
          valid_n      = !perr && rx_s;
          cnt_n        = '0;
          state_n      = rx_s ? IDLE : WAIT_HIGH;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/uart_rx_parity.md
Name: uart_rx_parity

Overview:
- Serial receiver for the XOR-parity serial link. It de-serialises one 8-bit frame at a time from a single-wire input and checks the frame's parity by XOR-reducing the received bits.
- Its transmitter counterpart on the same link generates the parity bit with the same XOR reduction.
- Sits between an external serial pin and a byte-wide consumer, such as a memory-mapped keyboard or IO register.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit. Must be at least 2 and even.
- ODD_PARITY, 0, parity sense. 0 means even: XOR of the 8 data bits and the parity bit must be 0. 1 means odd: that XOR must be 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- data  output  8  last received byte, LSB received first.
- valid  output  1  one-cycle pulse when a frame completes with no error.
- parity_err  output  1  error flag for the last completed frame.
- frame_err  output  1  error flag for the last completed frame.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values, while rst_n=0:
  - data=8'h00, valid=0, parity_err=0, frame_err=0, busy=0.
  - State=IDLE, both synchroniser flops=1, bit counter=0, cycle counter=0, parity accumulator=0.
- Input synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s.
- Frame format: start (0), d0..d7, parity bit, stop (1). Each bit is CLKS_PER_BIT cycles long.
- Cycle counter cnt, width clog2(CLKS_PER_BIT)+1.
- States:
  - IDLE:
    - On rx_s=0, go to START with cnt=0 and acc=ODD_PARITY.
  - START:
    - cnt increments each cycle.
    - At cnt=CLKS_PER_BIT/2-1 (mid start bit): if rx_s=0, go to DATA with cnt=0 and bit index=0.
    - Otherwise treat it as a glitch: return to IDLE with no outputs changed.
  - DATA:
    - cnt counts to CLKS_PER_BIT-1. On that cycle, sample rx_s into shift[bit index] and set acc ^= rx_s.
    - Then cnt=0 and bit index increments.
    - After d7 is sampled, go to PARITY.
  - PARITY:
    - At cnt=CLKS_PER_BIT-1, sample rx_s and set perr = acc ^ rx_s. Go to STOP.
  - STOP:
    - At cnt=CLKS_PER_BIT-1, sample rx_s and complete the frame (see completion rules below).
    - If stop=1, go to IDLE.
    - If stop=0, go to WAIT_HIGH.
  - WAIT_HIGH:
    - Stay until rx_s=1, then go to IDLE. No new frame can start from here.
- Completion, in the cycle after the stop sample:
  - data<=shift, parity_err<=perr, frame_err<=(stop==0).
  - valid=1 for exactly 1 cycle, and only if both errors are 0.
  - data and the error flags hold until the next completion. They update even on an errored frame.
- Sampling points: every bit is sampled at its midpoint relative to the detected start edge.
- Back-to-back frames: a start bit immediately following a stop bit must be accepted.
  - IDLE is re-entered before the next start edge is sampled.
  - No dead cycle is permitted beyond the synchroniser latency.
- Latency: valid rises 2 + CLKS_PER_BIT/2 + 10·CLKS_PER_BIT cycles after the rx falling edge, with ±1 cycle for edge alignment.
- Mid-frame reset: asserting rst_n low immediately forces all reset values. The interrupted frame is discarded, with no valid pulse and no flag update.
- A new frame requires a fresh high-to-low transition seen in IDLE.

Test Plan:
- Setup for all scenarios: CLKS_PER_BIT=4, ODD_PARITY=0 unless stated.
- Even-parity frame: send byte 8'hA5 with parity bit 0 and stop 1 -> valid pulses once, data=8'hA5, parity_err=0, frame_err=0, busy low afterwards.
- Parity error: send 8'h01 with parity bit 0 -> valid stays 0, parity_err=1, data=8'h01. A following good frame 8'h03 with parity 0 -> valid=1, parity_err clears to 0.
- Framing error: send 8'h3C with a correct parity bit and stop=0, then hold rx low for 20 cycles -> frame_err=1, no valid, state held in WAIT_HIGH (busy=1), no new frame started. Raising rx -> busy=0.
- Glitch rejection: drive rx low for 1 clock, then high -> busy drops back to 0 within 4 cycles; no outputs change.
- Back-to-back with odd parity: ODD_PARITY=1, send 8'hFF (parity bit 1) then 8'h00 (parity bit 1) with no idle gap -> two valid pulses 44 cycles apart, data 8'hFF then 8'h00.
- Reset mid-frame: pull rst_n low during d4 of frame 8'h5A -> data stays 8'h00, no valid. Then release and send 8'h5A (parity bit 0) -> valid, data=8'h5A.
